pipe_fanout: RTL and testbench

//   Registered broadcast tree: the distribution counterpart of the pipelined
//   AND-reduction tree. Replicates one WIDTH-bit value plus valid into COPIES

---
 rtl/pipe_fanout.sv | 98 +++++++++
 tb/tb_pipe_fanout.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_fanout.sv
// Registered broadcast tree: replicates one valid+data word into COPIES leaf
// registers through a pipelined tree in which no register drives more than FANOUT loads.
module pipe_fanout #(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       COPIES    = 32,
    parameter int unsigned       FANOUT    = 6,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic [COPIES-1:0]          out_valid,
    output logic [COPIES*WIDTH-1:0]    out_data,
    output logic                       primed
);

    function automatic int unsigned level_count(input int unsigned lvl);
        int unsigned n;
        n = COPIES;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = (n + FANOUT - 1) / FANOUT;
        end
        return n;
    endfunction

    function automatic int unsigned level_offset(input int unsigned lvl);
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < lvl; i++) begin
            sum = sum + level_count(i);
        end
        return sum;
    endfunction

    function automatic int unsigned calc_lat();
        int unsigned n;
        int unsigned lat;
        n   = COPIES;
        lat = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (n > FANOUT) begin
                n   = (n + FANOUT - 1) / FANOUT;
                lat = lat + 1;
            end
        end
        return lat;
    endfunction

    localparam int unsigned LAT   = calc_lat();
    localparam int unsigned NODES = level_offset(LAT);
    localparam int unsigned CW    = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LAT);

    // All tree nodes live in one flat vector: leaves at offset 0, root level last.
    logic [NODES-1:0]       vld_q, vld_d;
    logic [NODES*WIDTH-1:0] dat_q, dat_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    for (genvar lv = 0; lv < LAT; lv++) begin : g_level
        localparam int unsigned N   = level_count(lv);
        localparam int unsigned OFF = level_offset(lv);
        for (genvar k = 0; k < N; k++) begin : g_node
            if (lv == LAT - 1) begin : g_root
                assign vld_d[OFF + k]                   = in_valid;
                assign dat_d[(OFF + k)*WIDTH +: WIDTH]  = in_data;
            end else begin : g_inner
                localparam int unsigned SRC = level_offset(lv + 1) + k / FANOUT;
                assign vld_d[OFF + k]                   = vld_q[SRC];
                assign dat_d[(OFF + k)*WIDTH +: WIDTH]  = dat_q[SRC*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= {NODES{RESET_VAL}};
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = vld_q[COPIES-1:0];
    assign out_data  = dat_q[COPIES*WIDTH-1:0];
    assign primed    = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_pipe_fanout.sv
// Bench for pipe_fanout: three configurations (LAT 3, 2, 1) driven from shared
// inputs, checked against a constant table, hand sequences and a queue-based delay model.
module tb_pipe_fanout;

    localparam int NA = 37, NB = 32, NC = 6;
    localparam int LAT_A = 3, LAT_B = 2, LAT_C = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic [NA-1:0]   vA;
    logic [NA*8-1:0] dA;
    logic            pA;
    logic [NB-1:0]   vB;
    logic [NB-1:0]   dB;
    logic            pB;
    logic [NC-1:0]   vC;
    logic [NC*8-1:0] dC;
    logic            pC;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_fanout #(.WIDTH(8), .COPIES(37), .FANOUT(6), .RESET_VAL(8'h3C)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(vA), .out_data(dA), .primed(pA));

    pipe_fanout #(.WIDTH(1), .COPIES(32), .FANOUT(6), .RESET_VAL(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[0]),
        .out_valid(vB), .out_data(dB), .primed(pB));

    pipe_fanout #(.WIDTH(8), .COPIES(6), .FANOUT(6), .RESET_VAL(8'h00)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(vC), .out_data(dC), .primed(pC));

    // Reference model: each config shows the sample taken LAT edges ago, or reset values.
    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } samp_t;

    samp_t qA[$];
    samp_t qB[$];
    samp_t qC[$];

    typedef struct {
        logic iv; logic [7:0] id;
        logic av; logic [7:0] ad; logic ap;
        logic bv; logic       bd; logic bp;
        logic cv; logic [7:0] cd; logic cp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic ok, input string detail);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        samp_t s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (rst_n) begin
            s = '{v: v, d: d};
            qA.push_back(s); if (qA.size() > LAT_A) void'(qA.pop_front());
            qB.push_back(s); if (qB.size() > LAT_B) void'(qB.pop_front());
            qC.push_back(s); if (qC.size() > LAT_C) void'(qC.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        samp_t ea, eb, ec;
        logic  xa, xb, xc;
        xa = (qA.size() == LAT_A);
        xb = (qB.size() == LAT_B);
        xc = (qC.size() == LAT_C);
        if (xa) ea = qA[0]; else ea = '{v: 1'b0, d: 8'h3C};
        if (xb) eb = qB[0]; else eb = '{v: 1'b0, d: 8'h00};
        if (xc) ec = qC[0]; else ec = '{v: 1'b0, d: 8'h00};
        chk({tag, "/A"}, vA === {NA{ea.v}} && dA === {NA{ea.d}} && pA === xa,
            $sformatf("got v=%h d=%h p=%b want v=%b d=%h p=%b", vA, dA, pA, ea.v, ea.d, xa));
        chk({tag, "/B"}, vB === {NB{eb.v}} && dB === {NB{eb.d[0]}} && pB === xb,
            $sformatf("got v=%h d=%h p=%b want v=%b d=%b p=%b", vB, dB, pB, eb.v, eb.d[0], xb));
        chk({tag, "/C"}, vC === {NC{ec.v}} && dC === {NC{ec.d}} && pC === xc,
            $sformatf("got v=%h d=%h p=%b want v=%b d=%h p=%b", vC, dC, pC, ec.v, ec.d, xc));
    endtask

    // Called just after a falling edge; returns on a falling edge with rst_n released.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        qA.delete(); qB.delete(); qC.delete();
        #1;
        chk("async_reset", vA === '0 && dA === {NA{8'h3C}} && pA === 1'b0 &&
                           vB === '0 && dB === '0 && pB === 1'b0 &&
                           vC === '0 && dC === '0 && pC === 1'b0,
            $sformatf("got vA=%h dA=%h pA=%b vB=%h dB=%h pB=%b vC=%h dC=%h pC=%b want all-zero valid/primed, dA=3C x37",
                      vA, dA, pA, vB, dB, pB, vC, dC, pC));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
        tbl[1] = '{1'b0, 8'hFF, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1};
        tbl[2] = '{1'b1, 8'h01, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[3] = '{1'b1, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1};
        tbl[4] = '{1'b1, 8'h03, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].iv, tbl[i].id);
            chk($sformatf("tbl%0d/A", i),
                vA === {NA{tbl[i].av}} && dA === {NA{tbl[i].ad}} && pA === tbl[i].ap,
                $sformatf("got v=%h d=%h p=%b want v=%b d=%h p=%b", vA, dA, pA, tbl[i].av, tbl[i].ad, tbl[i].ap));
            chk($sformatf("tbl%0d/B", i),
                vB === {NB{tbl[i].bv}} && dB === {NB{tbl[i].bd}} && pB === tbl[i].bp,
                $sformatf("got v=%h d=%h p=%b want v=%b d=%b p=%b", vB, dB, pB, tbl[i].bv, tbl[i].bd, tbl[i].bp));
            chk($sformatf("tbl%0d/C", i),
                vC === {NC{tbl[i].cv}} && dC === {NC{tbl[i].cd}} && pC === tbl[i].cp,
                $sformatf("got v=%h d=%h p=%b want v=%b d=%h p=%b", vC, dC, pC, tbl[i].cv, tbl[i].cd, tbl[i].cp));
        end

        // Single-cycle pulse through the 32-copy tree: visible on exactly one sample.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h01);
        chk("pulse_t0", vB === '0 && dB === '0, $sformatf("got v=%h d=%h want v=0 d=0", vB, dB));
        step(1'b0, 8'h00);
        chk("pulse_t1", vB === '1 && dB === '1, $sformatf("got v=%h d=%h want all ones", vB, dB));
        step(1'b0, 8'h00);
        chk("pulse_t2", vB === '0 && dB === '0, $sformatf("got v=%h d=%h want v=0 d=0", vB, dB));
        check_all("pulse_end");

        // Stream 1,2,3... through the 37-copy tree with no gaps.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i));
            check_all($sformatf("stream%0d", i));
        end

        // Reset while a pulse is in flight: it must never surface.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h55);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00);
            chk($sformatf("midrst%0d", i),
                vA === '0 && vB === '0 && vC === '0 &&
                pA === (i >= 2) && pB === (i >= 1) && pC === 1'b1,
                $sformatf("got vA=%h vB=%h vC=%h pA=%b pB=%b pC=%b want valids 0 pA=%b pB=%b pC=1",
                          vA, vB, vC, pA, pB, pC, (i >= 2), (i >= 1)));
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 8'($urandom));
                check_all($sformatf("rand%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
